// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the single-cycle CPU: word RAM plus an MMIO window
// holding GPIO, a free-running cycle counter and a down-counting timer.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0000_FF00,
  parameter int unsigned GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DM_CS,
  input  logic              DM_R,
  input  logic              DM_W,
  input  logic [31:0]       maddr,
  input  logic [31:0]       mwdata,
  output logic [31:0]       mrdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [32:0] RAM_END = 33'(DEPTH) << 2;
  localparam logic [32:0] MMIO_LO = {1'b0, MMIO_BASE};
  localparam logic [32:0] MMIO_HI = MMIO_LO + 33'd256;

  localparam logic [5:0] W_GPIO  = 6'd0;
  localparam logic [5:0] W_CYCLE = 6'd1;
  localparam logic [5:0] W_LOAD  = 6'd2;
  localparam logic [5:0] W_CTRL  = 6'd3;
  localparam logic [5:0] W_COUNT = 6'd4;

  logic [31:0]       mem_q [DEPTH];
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       load_q, load_d;
  logic [31:0]       count_q, count_d;
  logic              en_q, en_d;
  logic              auto_q, auto_d;
  logic              stat_q, stat_d;

  logic              ram_hit, mmio_hit, rd_en, wr_en, expire;
  logic              gpio_wr, load_wr, ctrl_wr;
  logic [AW-1:0]     ram_idx;
  logic [5:0]        mmio_word;

  // 33-bit compares keep the window end from wrapping when MMIO_BASE sits near the top
  assign ram_hit   = ({1'b0, maddr} < RAM_END);
  assign mmio_hit  = ({1'b0, maddr} >= MMIO_LO) && ({1'b0, maddr} < MMIO_HI);
  assign ram_idx   = maddr[AW+1:2];
  assign mmio_word = maddr[7:2] - MMIO_BASE[7:2];
  assign rd_en     = DM_CS & DM_R;
  assign wr_en     = DM_CS & DM_W;
  assign gpio_wr   = wr_en & mmio_hit & (mmio_word == W_GPIO);
  assign load_wr   = wr_en & mmio_hit & (mmio_word == W_LOAD);
  assign ctrl_wr   = wr_en & mmio_hit & (mmio_word == W_CTRL);
  assign expire    = en_q & (count_q == 32'd1);

  assign gpio_out  = gpio_q;
  assign timer_irq = stat_q & en_q;

  always_comb begin
    mrdata = 32'h0;
    if (rd_en) begin
      if (ram_hit) begin
        mrdata = mem_q[ram_idx];
      end else if (mmio_hit) begin
        case (mmio_word)
          W_GPIO:  mrdata = 32'(gpio_q);
          W_CYCLE: mrdata = cycle_q;
          W_LOAD:  mrdata = load_q;
          W_CTRL:  mrdata = {29'h0, stat_q, auto_q, en_q};
          W_COUNT: mrdata = count_q;
          default: mrdata = 32'h0;
        endcase
      end
    end
  end

  // Priority: STAT clear < expiry set, and timer decrement/reload < LOAD write
  always_comb begin
    gpio_d  = gpio_q;
    cycle_d = cycle_q + 32'd1;
    load_d  = load_q;
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    stat_d  = stat_q;

    if (gpio_wr) gpio_d = mwdata[GPIO_W-1:0];

    if (ctrl_wr) begin
      en_d   = mwdata[0];
      auto_d = mwdata[1];
      if (mwdata[2]) stat_d = 1'b0;
    end

    if (en_q && (count_q > 32'd1)) begin
      count_d = count_q - 32'd1;
    end else if (expire) begin
      stat_d  = 1'b1;
      count_d = auto_q ? load_q : 32'h0;
    end

    if (load_wr) begin
      load_d  = mwdata;
      count_d = mwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q  <= '0;
      cycle_q <= '0;
      load_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      stat_q  <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      stat_q  <= stat_d;
    end
  end

  // RAM keeps its contents through reset, but a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && wr_en && ram_hit) mem_q[ram_idx] <= mwdata;
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder: RAM, decode, GPIO,
// cycle counter, one-shot/auto-reload timer and mid-run reset.
module tb_dmem_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        DM_CS, DM_R, DM_W;
  logic [31:0] maddr, mwdata;
  logic [31:0] mrdata;
  logic [15:0] gpio_out;
  logic        timer_irq;

  int num_checks = 0;
  int num_fail   = 0;
  int cyc_model  = 0;
  logic [31:0] c1, c2;

  localparam logic [31:0] A_GPIO  = 32'h0000_FF00;
  localparam logic [31:0] A_CYCLE = 32'h0000_FF04;
  localparam logic [31:0] A_LOAD  = 32'h0000_FF08;
  localparam logic [31:0] A_CTRL  = 32'h0000_FF0C;
  localparam logic [31:0] A_COUNT = 32'h0000_FF10;

  dmem_mmio_responder dut (
    .clk       (clk),
    .reset     (reset),
    .DM_CS     (DM_CS),
    .DM_R      (DM_R),
    .DM_W      (DM_W),
    .maddr     (maddr),
    .mwdata    (mwdata),
    .mrdata    (mrdata),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #10 clk = ~clk;

  task automatic applyStimulus(input logic cs, input logic r, input logic w,
                               input logic [31:0] addr, input logic [31:0] data);
    DM_CS  = cs;
    DM_R   = r;
    DM_W   = w;
    maddr  = addr;
    mwdata = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge; the cycle model mirrors the counter's reset/increment rule
  task automatic tick();
    @(posedge clk);
    if (reset) cyc_model = 0;
    else       cyc_model++;
    #1;
  endtask

  task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr,
                           input logic [31:0] expected);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0);
    #1;
    checkOutput(tag, mrdata, expected);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic readWord(input logic [31:0] addr, output logic [31:0] value);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0);
    #1;
    value = mrdata;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    #1;
    checkOutput("rst_mrdata_idle", mrdata, 32'h0);
    checkOutput("rst_gpio_out", 32'(gpio_out), 32'h0);
    checkOutput("rst_irq", 32'(timer_irq), 32'h0);
    readCheck("rst_cycle", A_CYCLE, 32'h0);
    readCheck("rst_count", A_COUNT, 32'h0);
    readCheck("rst_ctrl", A_CTRL, 32'h0);
    reset = 1'b0;

    // RAM and address decode
    writeWord(32'h0000_0010, 32'hDEAD_BEEF);
    readCheck("ram_read", 32'h0000_0010, 32'hDEAD_BEEF);
    readCheck("ram_read_unaligned", 32'h0000_0013, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    checkOutput("read_no_cs", mrdata, 32'h0);
    writeWord(32'h0000_0000, 32'h0000_0A0A);
    readCheck("unmapped_read", 32'h0000_5000, 32'h0);
    writeWord(32'h0000_5000, 32'h0000_0BAD);
    readCheck("unmapped_write_no_alias", 32'h0000_0000, 32'h0000_0A0A);

    // Same-cycle read and write return the old data
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0001);
    #1;
    checkOutput("rw_same_cycle_old", mrdata, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    readCheck("rw_same_cycle_new", 32'h0000_0010, 32'h0000_0001);

    // GPIO and cycle counter
    writeWord(A_GPIO, 32'h1234_ABCD);
    checkOutput("gpio_out", 32'(gpio_out), 32'h0000_ABCD);
    readCheck("gpio_read", A_GPIO, 32'h0000_ABCD);
    readWord(A_CYCLE, c1);
    checkOutput("cycle_abs", c1, 32'(cyc_model));
    for (int i = 0; i < 5; i++) tick();
    readWord(A_CYCLE, c2);
    checkOutput("cycle_delta", c2 - c1, 32'd5);
    writeWord(A_CYCLE, 32'h0000_0000);
    readCheck("cycle_write_ignored", A_CYCLE, 32'(cyc_model));

    // One-shot timer
    writeWord(A_LOAD, 32'd3);
    readCheck("oneshot_load_count", A_COUNT, 32'd3);
    writeWord(A_CTRL, 32'h1);
    readCheck("oneshot_count3", A_COUNT, 32'd3);
    tick();
    readCheck("oneshot_count2", A_COUNT, 32'd2);
    tick();
    readCheck("oneshot_count1", A_COUNT, 32'd1);
    checkOutput("oneshot_irq_before", 32'(timer_irq), 32'h0);
    tick();
    readCheck("oneshot_count0", A_COUNT, 32'd0);
    checkOutput("oneshot_irq_set", 32'(timer_irq), 32'h1);
    tick();
    readCheck("oneshot_count_hold", A_COUNT, 32'd0);
    readCheck("oneshot_ctrl_stat", A_CTRL, 32'h5);
    writeWord(A_CTRL, 32'h5);
    checkOutput("oneshot_irq_cleared", 32'(timer_irq), 32'h0);
    readCheck("oneshot_ctrl_after_clr", A_CTRL, 32'h1);

    // Auto-reload and collisions
    writeWord(A_CTRL, 32'h0);
    writeWord(A_LOAD, 32'd2);
    writeWord(A_CTRL, 32'h3);
    readCheck("auto_count2", A_COUNT, 32'd2);
    tick();
    readCheck("auto_count1", A_COUNT, 32'd1);
    checkOutput("auto_irq_low", 32'(timer_irq), 32'h0);
    tick();
    readCheck("auto_reload", A_COUNT, 32'd2);
    checkOutput("auto_irq_high", 32'(timer_irq), 32'h1);
    writeWord(A_CTRL, 32'h7);
    readCheck("auto_clr_count1", A_COUNT, 32'd1);
    checkOutput("auto_clr_irq", 32'(timer_irq), 32'h0);
    writeWord(A_CTRL, 32'h7);
    checkOutput("collide_set_wins", 32'(timer_irq), 32'h1);
    readCheck("collide_count_reload", A_COUNT, 32'd2);
    tick();
    readCheck("pre_load_collide", A_COUNT, 32'd1);
    writeWord(A_LOAD, 32'd5);
    readCheck("load_wins_count", A_COUNT, 32'd5);
    readCheck("load_wins_load", A_LOAD, 32'd5);
    checkOutput("load_collide_stat", 32'(timer_irq), 32'h1);

    // Reset mid-run overrides a concurrent GPIO write
    applyStimulus(1'b1, 1'b0, 1'b1, A_GPIO, 32'h0000_FFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("midrst_gpio_out", 32'(gpio_out), 32'h0);
    checkOutput("midrst_irq", 32'(timer_irq), 32'h0);
    readCheck("midrst_count", A_COUNT, 32'h0);
    readCheck("midrst_load", A_LOAD, 32'h0);
    readCheck("midrst_ctrl", A_CTRL, 32'h0);
    readCheck("midrst_cycle0", A_CYCLE, 32'h0);
    tick();
    readCheck("midrst_cycle1", A_CYCLE, 32'h1);
    readCheck("midrst_ram_kept", 32'h0000_0010, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
